// File: rtl/nor_op_identifier_pkg.sv
// Shared definitions for the NOR logic-unit observer: sel codes, reference
// truth tables (bit index = {a,b}) and the FSM state encoding.
package lab2_op_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;

    localparam logic [3:0] TT_NOT  = 4'b0011;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_NAND = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DECODE = 2'd3
    } state_t;

endpackage

// File: rtl/nor_op_identifier_if.sv
// Bus between the observer and whoever drives start / provides the unit's out.
interface nor_op_identifier_if;
    logic       start;
    logic       dut_out;
    logic       dut_a;
    logic       dut_b;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [2:0] sel_found;
    logic       valid_op;

    modport master (
        output start, dut_out,
        input  dut_a, dut_b, busy, done, truth_table, sel_found, valid_op
    );

    modport slave (
        input  start, dut_out,
        output dut_a, dut_b, busy, done, truth_table, sel_found, valid_op
    );
endinterface

// File: rtl/nor_op_identifier_decoder.sv
// Combinational truth-table to sel decoder. Sel 7 (second NAND) is
// indistinguishable from sel 6 and therefore always reported as 6.
module op_tt_decoder
    import lab2_op_pkg::*;
(
    input  logic [3:0] truth_table,
    output logic [2:0] sel_found,
    output logic       valid_op
);

    always_comb begin
        sel_found = OP_NOT;
        valid_op  = 1'b0;
        case (truth_table)
            TT_NOT:  begin sel_found = OP_NOT;  valid_op = 1'b1; end
            TT_NOR:  begin sel_found = OP_NOR;  valid_op = 1'b1; end
            TT_AND:  begin sel_found = OP_AND;  valid_op = 1'b1; end
            TT_OR:   begin sel_found = OP_OR;   valid_op = 1'b1; end
            TT_XOR:  begin sel_found = OP_XOR;  valid_op = 1'b1; end
            TT_XNOR: begin sel_found = OP_XNOR; valid_op = 1'b1; end
            TT_NAND: begin sel_found = OP_NAND; valid_op = 1'b1; end
            default: begin sel_found = OP_NOT;  valid_op = 1'b0; end
        endcase
    end

endmodule

// File: rtl/nor_op_identifier.sv
// Observer top: sweeps {a,b} over 00..11, samples the unit's out after a
// settle window, builds the truth table and registers the decoded sel.
module nor_op_identifier
    import lab2_op_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    nor_op_identifier_if.slave    bus
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [1:0] idx_reg, idx_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       dut_a_reg, dut_a_next;
    logic       dut_b_reg, dut_b_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic [3:0] tt_reg, tt_next;
    logic [2:0] sel_reg, sel_next;
    logic       valid_reg, valid_next;

    logic [2:0] dec_sel;
    logic       dec_valid;
    logic [1:0] idx_inc;

    op_tt_decoder u_decoder (
        .truth_table (tt_reg),
        .sel_found   (dec_sel),
        .valid_op    (dec_valid)
    );

    assign idx_inc = idx_reg + 2'd1;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        dut_a_next = dut_a_reg;
        dut_b_next = dut_b_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        tt_next    = tt_reg;
        sel_next   = sel_reg;
        valid_next = valid_reg;

        case (state_reg)
            ST_IDLE: begin
                // busy covers the done cycle, which is spent in IDLE
                busy_next = 1'b0;
                if (bus.start) begin
                    state_next = ST_SETTLE;
                    idx_next   = 2'd0;
                    cnt_next   = 4'd0;
                    dut_a_next = 1'b0;
                    dut_b_next = 1'b0;
                    tt_next    = 4'd0;
                    busy_next  = 1'b1;
                end
            end
            ST_SETTLE: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                tt_next[idx_reg] = bus.dut_out;
                if (idx_reg == 2'd3) begin
                    state_next = ST_DECODE;
                end else begin
                    state_next = ST_SETTLE;
                    idx_next   = idx_inc;
                    cnt_next   = 4'd0;
                    dut_a_next = idx_inc[1];
                    dut_b_next = idx_inc[0];
                end
            end
            ST_DECODE: begin
                sel_next   = dec_sel;
                valid_next = dec_valid;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 2'd0;
            cnt_reg   <= 4'd0;
            dut_a_reg <= 1'b0;
            dut_b_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            tt_reg    <= 4'd0;
            sel_reg   <= 3'd0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            dut_a_reg <= dut_a_next;
            dut_b_reg <= dut_b_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            tt_reg    <= tt_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.dut_a       = dut_a_reg;
    assign bus.dut_b       = dut_b_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.truth_table = tt_reg;
    assign bus.sel_found   = sel_reg;
    assign bus.valid_op    = valid_reg;

endmodule

// File: tb/tb_nor_op_identifier.sv
// Directed bench: models the 3-bit-select logic unit beside two observers
// (SETTLE_CYCLES 1 and 3) and scoreboards every identification run.
module tb_nor_op_identifier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nor_op_identifier_if bus0 ();
    nor_op_identifier_if bus1 ();

    nor_op_identifier #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    nor_op_identifier #(.SETTLE_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // mode 0 = logic unit, 1 = out tied low, 2 = out tied high
    int         mode0 = 0, mode1 = 0;
    logic [2:0] usel0 = 3'd0, usel1 = 3'd0;

    function automatic logic unit_out(input int mode, input logic [2:0] sel,
                                      input logic a, input logic b);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        case (sel)
            3'd0:    return ~a;
            3'd1:    return ~(a | b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            default: return ~(a & b);
        endcase
    endfunction

    always_comb bus0.dut_out = unit_out(mode0, usel0, bus0.dut_a, bus0.dut_b);
    always_comb bus1.dut_out = unit_out(mode1, usel1, bus1.dut_a, bus1.dut_b);

    typedef struct {
        logic [3:0] tt;
        logic [2:0] sel;
        logic       valid;
        int         lat;
    } exp_t;

    typedef struct {
        int         first_done;
        int         n_done;
        int         bad_pat;
        logic [3:0] tt;
        logic [2:0] sel;
        logic       valid;
        logic       busy_d;
        logic       busy_after;
        logic [3:0] tt1;
        logic [2:0] sel1;
        logic [11:0] snap;
    } res_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [2:0] hold_sel [2];
    logic [3:0] tt_tab  [8] = '{4'b0011, 4'b0001, 4'b1000, 4'b1110,
                                4'b0110, 4'b1001, 4'b0111, 4'b0111};
    logic [2:0] sel_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};

    task automatic chk(input string tag, input int run, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s run%0d: observed %0h expected %0h", tag, run, obs, exp);
        end
    endtask

    task automatic drive_start(input bit inst, input logic v);
        if (inst) bus1.start = v;
        else      bus0.start = v;
    endtask

    function automatic logic [11:0] outs(input bit inst);
        if (inst)
            return {bus1.busy, bus1.done, bus1.dut_a, bus1.dut_b,
                    bus1.truth_table, bus1.sel_found, bus1.valid_op};
        return {bus0.busy, bus0.done, bus0.dut_a, bus0.dut_b,
                bus0.truth_table, bus0.sel_found, bus0.valid_op};
    endfunction

    // Called at posedge+1: start is accepted on the next edge (edge 0).
    // p1/p2: extra start pulses sampled at those edges; rst_e: reset edge.
    task automatic sweep(input bit inst, input int p1, input int p2, input int rst_e,
                         input int n_edges, output res_t r);
        int          s;
        logic [11:0] o;
        s = inst ? 3 : 1;
        r = '{default: 0};
        r.first_done = -1;
        r.busy_after = 1'b1;
        drive_start(inst, 1'b1);
        @(posedge clk); #1;
        drive_start(inst, (p1 == 1) || (p2 == 1));
        rst = (rst_e == 1);
        for (int i = 1; i <= n_edges; i++) begin
            @(posedge clk); #1;
            o = outs(inst);
            if (o[10]) begin
                r.n_done++;
                if (r.first_done < 0) begin
                    r.first_done = i;
                    r.tt     = o[7:4];
                    r.sel    = o[3:1];
                    r.valid  = o[0];
                    r.busy_d = o[11];
                end
            end
            if (r.first_done > 0 && i == r.first_done + 1) r.busy_after = o[11];
            if (i == 1) begin
                r.tt1  = o[7:4];
                r.sel1 = o[3:1];
            end
            if (i == rst_e) r.snap = o;
            if (rst_e == 0 && i < 4 * (s + 1) && o[9:8] != 2'(i / (s + 1))) r.bad_pat++;
            drive_start(inst, (i + 1 == p1) || (i + 1 == p2));
            rst = (i + 1 == rst_e);
        end
    endtask

    task automatic score(input bit inst, input int run, input res_t r);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", run, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("latency",      run, 32'(r.first_done), 32'(e.lat));
        chk("done_count",   run, 32'(r.n_done),     32'd1);
        chk("truth_table",  run, 32'(r.tt),         32'(e.tt));
        chk("sel_found",    run, 32'(r.sel),        32'(e.sel));
        chk("valid_op",     run, 32'(r.valid),      32'(e.valid));
        chk("busy_at_done", run, 32'(r.busy_d),     32'd1);
        chk("busy_after",   run, 32'(r.busy_after), 32'd0);
        chk("tt_cleared",   run, 32'(r.tt1),        32'd0);
        chk("sel_hold",     run, 32'(r.sel1),       32'(hold_sel[inst]));
        chk("ab_pattern",   run, 32'(r.bad_pat),    32'd0);
        hold_sel[inst] = e.sel;
    endtask

    initial begin
        res_t r;
        int   run;
        run = 0;
        hold_sel[0] = 3'd0;
        hold_sel[1] = 3'd0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs0", run, 32'(outs(0)), 32'd0);
        chk("reset_outs1", run, 32'(outs(1)), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int s = 0; s < 8; s++) begin
            run++;
            usel0 = 3'(s);
            sb.push_back('{tt_tab[s], sel_tab[s], 1'b1, 9});
            sweep(1'b0, 0, 0, 0, 12, r);
            score(1'b0, run, r);
            $display("run%0d sel=%0d tt=%b sel_found=%0d valid=%0b done@%0d",
                     run, s, r.tt, r.sel, r.valid, r.first_done);
        end

        for (int m = 1; m <= 2; m++) begin
            run++;
            mode0 = m;
            sb.push_back('{(m == 1) ? 4'b0000 : 4'b1111, 3'd0, 1'b0, 9});
            sweep(1'b0, 0, 0, 0, 12, r);
            score(1'b0, run, r);
            $display("run%0d out tied %0d tt=%b valid=%0b", run, m - 1, r.tt, r.valid);
        end
        mode0 = 0;

        run++;
        usel0 = 3'd3;
        sb.push_back('{4'b1110, 3'd3, 1'b1, 9});
        sweep(1'b0, 3, 8, 0, 12, r);
        score(1'b0, run, r);
        $display("run%0d start re-pulsed at edges 3,8: dones=%0d done@%0d",
                 run, r.n_done, r.first_done);

        run++;
        usel0 = 3'd6;
        sweep(1'b0, 0, 0, 5, 12, r);
        chk("rst_outs",   run, 32'(r.snap),   32'd0);
        chk("rst_nodone", run, 32'(r.n_done), 32'd0);
        hold_sel[0] = 3'd0;
        $display("run%0d reset at edge 5: outs=%h dones=%0d", run, r.snap, r.n_done);

        run++;
        sb.push_back('{4'b0111, 3'd6, 1'b1, 9});
        sweep(1'b0, 0, 0, 0, 12, r);
        score(1'b0, run, r);
        $display("run%0d after reset: tt=%b sel_found=%0d done@%0d",
                 run, r.tt, r.sel, r.first_done);

        run++;
        usel1 = 3'd4;
        sb.push_back('{4'b0110, 3'd4, 1'b1, 17});
        sweep(1'b1, 0, 0, 0, 20, r);
        score(1'b1, run, r);
        $display("run%0d settle=3 sel=4: tt=%b sel_found=%0d done@%0d",
                 run, r.tt, r.sel, r.first_done);

        chk("sb_drained", run, 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
